// File: rtl/mem_bus_router_if.sv
// rtl/mem_bus_router_if.sv - CPU, DRAM and peripheral bus signals of the memory router
interface mem_bus_router_if;
  logic        memory_read_req;
  logic        memory_write_req;
  logic [25:0] memory_addr;
  logic [31:0] memory_data_write;
  logic [31:0] memory_data_read;
  logic        memory_busy;
  logic        dram_req;
  logic        dram_we;
  logic [24:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic        dram_ack;
  logic        per_req;
  logic        per_we;
  logic [7:0]  per_addr;
  logic [31:0] per_wdata;
  logic [31:0] per_rdata;
  logic        per_ack;
  logic        bus_error;
  logic        err_clr;

  // slave is the router itself; master is the surrounding CPU and target side
  modport slave (
    input  memory_read_req, memory_write_req, memory_addr, memory_data_write,
    output memory_data_read, memory_busy,
    output dram_req, dram_we, dram_addr, dram_wdata,
    input  dram_rdata, dram_ack,
    output per_req, per_we, per_addr, per_wdata,
    input  per_rdata, per_ack,
    output bus_error,
    input  err_clr
  );

  modport master (
    output memory_read_req, memory_write_req, memory_addr, memory_data_write,
    input  memory_data_read, memory_busy,
    input  dram_req, dram_we, dram_addr, dram_wdata,
    output dram_rdata, dram_ack,
    input  per_req, per_we, per_addr, per_wdata,
    output per_rdata, per_ack,
    input  bus_error,
    output err_clr
  );
endinterface

// File: rtl/mem_bus_router.sv
// rtl/mem_bus_router.sv - routes single-outstanding CPU memory bus to DRAM or peripherals with a watchdog
module mem_bus_router #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic           clk,
  input  logic           reset,
  mem_bus_router_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAM_WAIT, PER_WAIT} state_t;

  state_t      state;
  logic [15:0] watchdog;
  logic        write_op;
  logic        cur_ack;
  logic [31:0] cur_rdata;
  logic        timeout_hit;

  // Only the ack of the target being waited on counts; anything else is stray
  always_comb begin
    cur_ack   = 1'b0;
    cur_rdata = 32'd0;
    case (state)
      DRAM_WAIT: begin
        cur_ack   = bus.dram_ack;
        cur_rdata = bus.dram_rdata;
      end
      PER_WAIT: begin
        cur_ack   = bus.per_ack;
        cur_rdata = bus.per_rdata;
      end
      default: ;
    endcase
    timeout_hit = (state != IDLE) && !cur_ack && (watchdog == 16'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      watchdog             <= 16'd0;
      write_op             <= 1'b0;
      bus.memory_data_read <= 32'd0;
      bus.memory_busy      <= 1'b0;
      bus.dram_req         <= 1'b0;
      bus.dram_we          <= 1'b0;
      bus.dram_addr        <= 25'd0;
      bus.dram_wdata       <= 32'd0;
      bus.per_req          <= 1'b0;
      bus.per_we           <= 1'b0;
      bus.per_addr         <= 8'd0;
      bus.per_wdata        <= 32'd0;
      bus.bus_error        <= 1'b0;
    end else begin
      if (timeout_hit)
        bus.bus_error <= 1'b1;
      else if (bus.err_clr)
        bus.bus_error <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.memory_read_req || bus.memory_write_req) begin
            write_op        <= bus.memory_write_req;
            watchdog        <= 16'd0;
            bus.memory_busy <= 1'b1;
            if (bus.memory_addr[25]) begin
              bus.per_req   <= 1'b1;
              bus.per_we    <= bus.memory_write_req;
              bus.per_addr  <= bus.memory_addr[7:0];
              bus.per_wdata <= bus.memory_data_write;
              state         <= PER_WAIT;
            end else begin
              bus.dram_req   <= 1'b1;
              bus.dram_we    <= bus.memory_write_req;
              bus.dram_addr  <= bus.memory_addr[24:0];
              bus.dram_wdata <= bus.memory_data_write;
              state          <= DRAM_WAIT;
            end
          end
        end
        DRAM_WAIT, PER_WAIT: begin
          if (cur_ack || timeout_hit) begin
            if (!write_op)
              bus.memory_data_read <= cur_ack ? cur_rdata : ERR_DATA;
            bus.dram_req    <= 1'b0;
            bus.per_req     <= 1'b0;
            bus.memory_busy <= 1'b0;
            state           <= IDLE;
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_router.sv
// tb/tb_mem_bus_router.sv - table-driven self-checking bench for mem_bus_router
module tb_mem_bus_router;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_bus_router_if bus();

  mem_bus_router #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [25:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] rdata;
    logic        stray;
    int          exp_busy;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic        sel_per;
    logic        other_seen;
    int          n;
    int          req_cycles;
    sel_per = v.addr[25];
    @(negedge clk);
    bus.memory_read_req   = v.rd;
    bus.memory_write_req  = v.wr;
    bus.memory_addr       = v.addr;
    bus.memory_data_write = v.wdata;
    @(posedge clk);
    @(negedge clk);
    bus.memory_read_req  = 1'b0;
    bus.memory_write_req = 1'b0;
    chk({tag, " busy_rise"}, 32'(bus.memory_busy), 32'd1);
    if (sel_per) begin
      chk({tag, " per_addr"}, 32'(bus.per_addr), 32'(v.addr[7:0]));
      chk({tag, " per_we"}, 32'(bus.per_we), 32'(v.wr));
      if (v.wr) chk({tag, " per_wdata"}, bus.per_wdata, v.wdata);
    end else begin
      chk({tag, " dram_addr"}, 32'(bus.dram_addr), 32'(v.addr[24:0]));
      chk({tag, " dram_we"}, 32'(bus.dram_we), 32'(v.wr));
      if (v.wr) chk({tag, " dram_wdata"}, bus.dram_wdata, v.wdata);
    end
    n = 0;
    req_cycles = 0;
    other_seen = 1'b0;
    while (bus.memory_busy && n < 40) begin
      if (sel_per ? bus.per_req : bus.dram_req) req_cycles++;
      if (sel_per ? bus.dram_req : bus.per_req) other_seen = 1'b1;
      if (n == v.ack_dly) begin
        if (sel_per) begin bus.per_ack = 1'b1; bus.per_rdata = v.rdata; end
        else begin bus.dram_ack = 1'b1; bus.dram_rdata = v.rdata; end
      end
      if (v.stray && n == 0) begin
        if (sel_per) begin bus.dram_ack = 1'b1; bus.dram_rdata = 32'hFFFFFFFF; end
        else begin bus.per_ack = 1'b1; bus.per_rdata = 32'hFFFFFFFF; end
      end
      @(posedge clk);
      @(negedge clk);
      bus.dram_ack = 1'b0;
      bus.per_ack  = 1'b0;
      n++;
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'(v.exp_busy));
    chk({tag, " req_cycles"}, 32'(req_cycles), 32'(v.exp_busy));
    chk({tag, " other_req"}, 32'(other_seen), 32'd0);
    chk({tag, " req_drop"}, 32'(bus.dram_req | bus.per_req), 32'd0);
    chk({tag, " data_read"}, bus.memory_data_read, v.exp_rd);
    chk({tag, " bus_error"}, 32'(bus.bus_error), 32'(v.exp_err));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.memory_read_req   = 1'b0;
    bus.memory_write_req  = 1'b0;
    bus.memory_addr       = 26'd0;
    bus.memory_data_write = 32'd0;
    bus.dram_rdata        = 32'd0;
    bus.dram_ack          = 1'b0;
    bus.per_rdata         = 32'd0;
    bus.per_ack           = 1'b0;
    bus.err_clr           = 1'b0;

    //          wr    rd    addr          wdata         dly rdata         stray busy exp_rd        err
    vecs[0] = '{1'b0, 1'b1, 26'h0000010, 32'h0,        3, 32'h12345678, 1'b1, 4, 32'h12345678, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 26'h20000A5, 32'hCAFEF00D, 0, 32'h55555555, 1'b0, 1, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 26'h1234567, 32'hA5A5A5A5, 1, 32'h11111111, 1'b0, 2, 32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 26'h3FFFF3C, 32'h0,        2, 32'h0BADF00D, 1'b1, 3, 32'h0BADF00D, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 26'h1FFFFFF, 32'h0,        7, 32'h87654321, 1'b0, 8, 32'h87654321, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 26'h0000100, 32'h0,       -1, 32'h0,        1'b0, 8, 32'hDEADBEEF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 26'h0000200, 32'h13579BDF,-1, 32'h0,        1'b0, 8, 32'hDEADBEEF, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst busy", 32'(bus.memory_busy), 32'd0);
    chk("rst dram_req", 32'(bus.dram_req), 32'd0);
    chk("rst per_req", 32'(bus.per_req), 32'd0);
    chk("rst data_read", bus.memory_data_read, 32'd0);
    chk("rst bus_error", 32'(bus.bus_error), 32'd0);
    chk("rst dram_addr", 32'(bus.dram_addr), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // err_clr pulse drops the sticky error
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("err_clr", 32'(bus.bus_error), 32'd0);

    // stray dram ack while idle
    bus.dram_ack   = 1'b1;
    bus.dram_rdata = 32'h33333333;
    @(negedge clk);
    bus.dram_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack busy", 32'(bus.memory_busy), 32'd0);
    chk("idle_ack data", bus.memory_data_read, 32'hDEADBEEF);
    chk("idle_ack req", 32'(bus.dram_req), 32'd0);

    // late ack after a timeout is ignored
    run_txn('{1'b0, 1'b1, 26'h0000300, 32'h0, -1, 32'h0, 1'b0, 8, 32'hDEADBEEF, 1'b1}, "late");
    bus.dram_ack   = 1'b1;
    bus.dram_rdata = 32'h22222222;
    @(negedge clk);
    bus.dram_ack = 1'b0;
    @(negedge clk);
    chk("late_ack data", bus.memory_data_read, 32'hDEADBEEF);
    chk("late_ack busy", 32'(bus.memory_busy), 32'd0);

    // reset while waiting on the peripheral
    bus.memory_read_req = 1'b1;
    bus.memory_addr     = 26'h2000001;
    @(posedge clk);
    @(negedge clk);
    bus.memory_read_req = 1'b0;
    chk("pre_rst per_req", 32'(bus.per_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst per_req", 32'(bus.per_req), 32'd0);
    chk("mid_rst busy", 32'(bus.memory_busy), 32'd0);
    chk("mid_rst data", bus.memory_data_read, 32'd0);
    chk("mid_rst err", 32'(bus.bus_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/mem_bus_router.md
# mem_bus_router

Routes the processor's single-outstanding memory bus (read/write request, 26-bit word address, 32-bit data, busy) from the control unit to one of two downstream targets: the DRAM controller port or the peripheral register file. It sits between the control unit and the hardware abstraction layer. It owns address decode, the request/acknowledge handshake with each target, and a per-transaction watchdog that stops a hung target from stalling the CPU.

## Interface

Parameters:
- TIMEOUT_CYCLES, 1023, wait-state cycles allowed before the transaction is aborted (range 1..65535)
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high; all state clears immediately
- memory_read_req  in  1  CPU read request
- memory_write_req  in  1  CPU write request
- memory_addr  in  26  CPU word address
- memory_data_write  in  32  CPU write data
- memory_data_read  out  32  read data returned to the CPU
- memory_busy  out  1  transaction in progress
- dram_req / dram_we  out  1 / 1  DRAM request, write enable
- dram_addr  out  25  DRAM word address
- dram_wdata  out  32  DRAM write data
- dram_rdata  in  32  DRAM read data, valid with dram_ack
- dram_ack  in  1  DRAM completion, one-cycle pulse
- per_req / per_we  out  1 / 1  peripheral request, write enable
- per_addr  out  8  peripheral register index
- per_wdata  out  32  peripheral write data
- per_rdata  in  32  peripheral read data, valid with per_ack
- per_ack  in  1  peripheral completion, one-cycle pulse
- bus_error  out  1  sticky timeout flag
- err_clr  in  1  clears bus_error

## Operation

- Decode: memory_addr[25]=0 selects DRAM, with dram_addr=memory_addr[24:0]. memory_addr[25]=1 selects the peripheral, with per_addr=memory_addr[7:0]; bits [24:8] are ignored.
- FSM states: IDLE, DRAM_WAIT, PER_WAIT.
- IDLE: a request is accepted when read_req or write_req is high.
  - Address, write data and direction are latched.
  - The next state is DRAM_WAIT or PER_WAIT.
  - If read_req and write_req are both high, the write wins.
  - Requests seen outside IDLE are ignored.
- WAIT states:
  - The target's req is high and addr/we/wdata are held stable.
  - The watchdog counter starts at 0 and increments once per WAIT cycle.
- Completion on ack (the ack is sampled while the matching WAIT state is active):
  - For a read, memory_data_read loads the target rdata.
  - For a write, memory_data_read is unchanged.
  - The FSM returns to IDLE and req drops.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no ack in that cycle:
  - req drops and the FSM returns to IDLE.
  - bus_error is set.
  - For a read, memory_data_read loads ERR_DATA.
- Ack and timeout in the same cycle: the ack wins and bus_error is not set.
- Stray acks are ignored with no state change:
  - an ack while in IDLE;
  - an ack from the non-selected target;
  - a late ack that arrives after a timeout.
- bus_error: set by a timeout, cleared by err_clr. If both happen in the same cycle, the set wins.
- memory_busy is registered and is high exactly when the state is not IDLE.
- Reset mid-transaction: the FSM goes to IDLE, req deasserts immediately, and nothing is returned to the CPU.
- Reset values: memory_data_read=0, memory_busy=0, dram_req=per_req=0, dram_we=per_we=0, all addr/wdata outputs=0, bus_error=0, watchdog=0.

## Timing

- Request sampled at edge T; busy and target req go high at T+1.
- If ack arrives at edge A (A ≥ T+1), then at A+1:
  - busy=0 and req=0;
  - memory_data_read is valid.
- Minimum latency, request to busy low: 2 cycles.
- Timeout: req is high for exactly TIMEOUT_CYCLES cycles. Busy falls at T+1+TIMEOUT_CYCLES.
- A back-to-back request can be accepted in the first cycle busy is low. The next req rises one cycle later, so req is low for at least one cycle between transactions.
- All downstream outputs are registered. There is no combinational path from any ack to any output.

## Test plan

- DRAM read: addr=0x0000010, dram_rdata=0x12345678 with ack 3 cycles after req. Expect:
  - dram_addr=0x0000010, dram_we=0;
  - busy high for 4 cycles;
  - memory_data_read=0x12345678;
  - per_req never asserted.
- Peripheral write: addr=0x20000A5, data=0xCAFEF00D, per_ack on the first req cycle. Expect:
  - per_addr=0xA5, per_we=1, per_wdata=0xCAFEF00D;
  - busy high for 1 cycle;
  - memory_data_read unchanged.
- Timeout: TIMEOUT_CYCLES=8, DRAM read, no ack. Expect:
  - dram_req high for 8 cycles;
  - memory_data_read=0xDEADBEEF;
  - bus_error=1.
  - err_clr pulse then returns bus_error to 0.
- Simultaneous and stray events:
  - read_req and write_req together → a DRAM write is issued.
  - dram_ack in IDLE → no change.
  - ack on the timeout cycle → normal completion with bus_error=0.
- Reset mid-transaction: reset asserted while in PER_WAIT. Expect:
  - per_req=0 and busy=0 immediately;
  - after release, a new DRAM read completes normally.
